// File: rtl/spi_fifo_tx.sv
// ---------------------------------------------------------------------------
// spi_fifo_tx
//   SPI master transmitter (mode 0, MSB first) that drains a byte FIFO.
//   Whenever enabled and the FIFO holds data, one byte is popped, shifted out
//   on mosi/sclk, and the next byte follows with cs_n held low. cs_n rises
//   once the FIFO runs dry or enable is low when a byte finishes.
//
//   Handshake with the FIFO: fifo_rd is a one-cycle pop strobe issued only
//   while fifo_empty was low when sampled; fifo_data is consumed on the cycle
//   after the strobe. fifo_empty and enable are looked at only in IDLE and
//   DONE, so a byte in flight always completes.
//
// Parameters
//   CLK_DIV     clk cycles per sclk half-period (>= 1)
//
// Ports
//   clk         system clock, everything on posedge
//   rst         synchronous active-low reset
//   enable      permission to start new bytes
//   fifo_empty  FIFO has no unread byte
//   fifo_data   FIFO read data, valid the cycle after fifo_rd
//   fifo_rd     one-cycle pop strobe
//   sclk        SPI clock, idles low
//   mosi        SPI data out
//   cs_n        SPI chip select, active low
//   busy        high in every state except IDLE
//   byte_done   one-cycle pulse when a byte has been fully sent
//   tx_count    bytes sent since reset, wraps at 256
// ---------------------------------------------------------------------------
module spi_fifo_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    output logic       busy,
    output logic       byte_done,
    output logic [7:0] tx_count
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    // Bit 7 of the byte goes straight to mosi on load, so only the
    // remaining seven bits need to be held for shifting.
    logic [6:0]       shreg_q, shreg_d;
    logic             fifo_rd_q, fifo_rd_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;
    logic             busy_q, busy_d;
    logic             byte_done_q, byte_done_d;
    logic [7:0]       tx_count_q, tx_count_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            fifo_rd_q   <= 1'b0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            byte_done_q <= 1'b0;
            tx_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            fifo_rd_q   <= fifo_rd_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
            busy_q      <= busy_d;
            byte_done_q <= byte_done_d;
            tx_count_q  <= tx_count_d;
        end
    end

    // Output registers are loaded with the value they must show in the
    // state being entered, so fifo_rd is high exactly during FETCH and
    // byte_done exactly during DONE.
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        fifo_rd_d   = 1'b0;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        cs_n_d      = cs_n_q;
        byte_done_d = 1'b0;
        tx_count_d  = tx_count_q;

        case (state_q)
            S_IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                if (enable && !fifo_empty) begin
                    state_d   = S_FETCH;
                    fifo_rd_d = 1'b1;
                end
            end
            S_FETCH: begin
                // cs_n falls as LOAD begins, a full half-period plus one
                // cycle ahead of the first rising sclk.
                state_d = S_LOAD;
                cs_n_d  = 1'b0;
            end
            S_LOAD: begin
                shreg_d   = fifo_data[6:0];
                mosi_d    = fifo_data[7];
                cs_n_d    = 1'b0;
                div_cnt_d = '0;
                bit_cnt_d = '0;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    sclk_d    = ~sclk_q;
                    if (!sclk_q) begin
                        // Rising edge: the slave samples the current bit.
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (bit_cnt_q < 4'd8) begin
                        // Falling edge: present the next bit.
                        mosi_d  = shreg_q[6];
                        shreg_d = {shreg_q[5:0], 1'b0};
                    end else begin
                        // Falling edge after the eighth bit ends the byte.
                        state_d     = S_DONE;
                        byte_done_d = 1'b1;
                        tx_count_d  = tx_count_q + 8'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            S_DONE: begin
                if (enable && !fifo_empty) begin
                    state_d   = S_FETCH;
                    fifo_rd_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign fifo_rd   = fifo_rd_q;
    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign cs_n      = cs_n_q;
    assign busy      = busy_q;
    assign byte_done = byte_done_q;
    assign tx_count  = tx_count_q;

endmodule

// File: tb/tb_spi_fifo_tx.sv
// ---------------------------------------------------------------------------
// tb_spi_fifo_tx
//   Two instances share clk/rst: dut0 runs with CLK_DIV=2, dut1 with
//   CLK_DIV=1. Each has a small array-backed FIFO model; a negedge monitor
//   pops the FIFO on fifo_rd, collects bytes from mosi at sclk rises and
//   tracks pulse counts, pop spacing and cs_n low-run lengths.
// ---------------------------------------------------------------------------
module tb_spi_fifo_tx;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // dut0 (CLK_DIV=2)
    logic       enable0 = 1'b0;
    logic       fifo_empty0;
    logic [7:0] fifo_data0 = 8'h00;
    logic       fifo_rd0, sclk0, mosi0, cs_n0, busy0, byte_done0;
    logic [7:0] tx_count0;

    // dut1 (CLK_DIV=1)
    logic       enable1 = 1'b0;
    logic       fifo_empty1;
    logic [7:0] fifo_data1 = 8'h00;
    logic       fifo_rd1, sclk1, mosi1, cs_n1, busy1, byte_done1;
    logic [7:0] tx_count1;

    spi_fifo_tx #(.CLK_DIV(2)) dut0 (
        .clk(clk), .rst(rst), .enable(enable0), .fifo_empty(fifo_empty0),
        .fifo_data(fifo_data0), .fifo_rd(fifo_rd0), .sclk(sclk0), .mosi(mosi0),
        .cs_n(cs_n0), .busy(busy0), .byte_done(byte_done0), .tx_count(tx_count0)
    );

    spi_fifo_tx #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable1), .fifo_empty(fifo_empty1),
        .fifo_data(fifo_data1), .fifo_rd(fifo_rd1), .sclk(sclk1), .mosi(mosi1),
        .cs_n(cs_n1), .busy(busy1), .byte_done(byte_done1), .tx_count(tx_count1)
    );

    // FIFO models: writes from tasks only, reads from the monitor only.
    logic [7:0] mem0 [512];
    logic [7:0] mem1 [512];
    logic [8:0] wp0 = 9'd0, rp0 = 9'd0;
    logic [8:0] wp1 = 9'd0, rp1 = 9'd0;
    assign fifo_empty0 = (wp0 == rp0);
    assign fifo_empty1 = (wp1 == rp1);

    int total = 0;
    int bad   = 0;

    // Monitor state
    int         cyc = 0;
    int         pop_err = 0;
    int         sclk_bad = 0;
    int         rd_cnt0 = 0, last_rd0 = 0, rd_gap0 = 0, done_cnt0 = 0, rise_cnt0 = 0;
    int         rx_n0 = 0, cs_run0 = 0;
    logic       sclk_prev0 = 1'b0;
    logic [7:0] rx_sh0 = 8'h00;
    logic [7:0] rx_q0[$];
    int         cs_runs0[$];
    int         rd_cnt1 = 0, last_rd1 = 0, gap_bad1 = 0, done_cnt1 = 0, rx_n1 = 0;
    logic       sclk_prev1 = 1'b0;
    logic [7:0] rx_sh1 = 8'h00;
    logic [7:0] rx_q1[$];

    always @(negedge clk) begin
        cyc++;
        // ---- dut0 ----
        if (fifo_rd0) begin
            if (wp0 == rp0) pop_err++;
            else begin
                fifo_data0 = mem0[rp0];
                rp0 = rp0 + 9'd1;
            end
            if (rd_cnt0 > 0) rd_gap0 = cyc - last_rd0;
            last_rd0 = cyc;
            rd_cnt0++;
        end
        if (byte_done0) done_cnt0++;
        if (sclk0 && !sclk_prev0) begin
            rise_cnt0++;
            rx_sh0 = {rx_sh0[6:0], mosi0};
            rx_n0++;
            if (rx_n0 == 8) begin
                rx_q0.push_back(rx_sh0);
                rx_n0 = 0;
            end
        end
        if (cs_n0) rx_n0 = 0;
        sclk_prev0 = sclk0;
        if (sclk0 && cs_n0) sclk_bad++;
        if (!cs_n0) cs_run0++;
        else if (cs_run0 != 0) begin
            cs_runs0.push_back(cs_run0);
            cs_run0 = 0;
        end
        // ---- dut1 ----
        if (fifo_rd1) begin
            if (wp1 == rp1) pop_err++;
            else begin
                fifo_data1 = mem1[rp1];
                rp1 = rp1 + 9'd1;
            end
            if (rd_cnt1 > 0 && (cyc - last_rd1) != 19) gap_bad1++;
            last_rd1 = cyc;
            rd_cnt1++;
        end
        if (byte_done1) done_cnt1++;
        if (sclk1 && !sclk_prev1) begin
            rx_sh1 = {rx_sh1[6:0], mosi1};
            rx_n1++;
            if (rx_n1 == 8) begin
                rx_q1.push_back(rx_sh1);
                rx_n1 = 0;
            end
        end
        if (cs_n1) rx_n1 = 0;
        sclk_prev1 = sclk1;
        if (sclk1 && cs_n1) sclk_bad++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push0(input logic [7:0] b);
        mem0[wp0] = b;
        wp0 = wp0 + 9'd1;
    endtask

    task automatic push1(input logic [7:0] b);
        mem1[wp1] = b;
        wp1 = wp1 + 9'd1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
    endtask

    // Wait for dut0 to go busy and then return to IDLE.
    task automatic wait_idle0(output bit ok);
        int n;
        ok = 1'b0;
        n = 0;
        while (!busy0 && n < 20) begin tick(); n++; end
        n = 0;
        while (busy0 && n < 2000) begin tick(); n++; end
        ok = !busy0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        total++; if (cs_n0 !== 1'b1)      begin bad++; $display("FAIL reset_cs_n got=%b exp=1", cs_n0); end
        total++; if (sclk0 !== 1'b0)      begin bad++; $display("FAIL reset_sclk got=%b exp=0", sclk0); end
        total++; if (mosi0 !== 1'b0)      begin bad++; $display("FAIL reset_mosi got=%b exp=0", mosi0); end
        total++; if (fifo_rd0 !== 1'b0)   begin bad++; $display("FAIL reset_fifo_rd got=%b exp=0", fifo_rd0); end
        total++; if (busy0 !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", busy0); end
        total++; if (byte_done0 !== 1'b0) begin bad++; $display("FAIL reset_byte_done got=%b exp=0", byte_done0); end
        total++; if (tx_count0 !== 8'd0)  begin bad++; $display("FAIL reset_tx_count got=%0d exp=0", tx_count0); end
        total++; if (tx_count1 !== 8'd0)  begin bad++; $display("FAIL reset_tx_count1 got=%0d exp=0", tx_count1); end
    endtask

    task automatic test_single();
        int rd_s, done_s, rx_s, cs_s;
        bit ok;
        rd_s = rd_cnt0; done_s = done_cnt0; rx_s = rx_q0.size(); cs_s = cs_runs0.size();
        enable0 = 1'b1;
        push0(8'hA5);
        wait_idle0(ok);
        tick();
        total++; if (!ok) begin bad++; $display("FAIL single_timeout busy=%b exp=0", busy0); end
        total++; if (rd_cnt0 - rd_s !== 1) begin bad++; $display("FAIL single_pops got=%0d exp=1", rd_cnt0 - rd_s); end
        total++; if (done_cnt0 - done_s !== 1) begin bad++; $display("FAIL single_byte_done got=%0d exp=1", done_cnt0 - done_s); end
        total++; if (tx_count0 !== 8'd1) begin bad++; $display("FAIL single_tx_count got=%0d exp=1", tx_count0); end
        total++;
        if (rx_q0.size() != rx_s + 1) begin bad++; $display("FAIL single_rx_count got=%0d exp=%0d", rx_q0.size(), rx_s + 1); end
        else if (rx_q0[rx_s] !== 8'hA5) begin bad++; $display("FAIL single_rx_data got=%h exp=a5", rx_q0[rx_s]); end
        total++;
        if (cs_runs0.size() != cs_s + 1) begin bad++; $display("FAIL single_cs_runs got=%0d exp=%0d", cs_runs0.size(), cs_s + 1); end
        else if (cs_runs0[cs_s] != 34) begin bad++; $display("FAIL single_cs_low got=%0d exp=34", cs_runs0[cs_s]); end
        total++; if (cs_n0 !== 1'b1 || sclk0 !== 1'b0) begin bad++; $display("FAIL single_idle cs_n=%b sclk=%b exp=1/0", cs_n0, sclk0); end
    endtask

    task automatic test_back_to_back();
        int rd_s, rx_s, cs_s;
        bit ok;
        do_reset();
        rd_s = rd_cnt0; rx_s = rx_q0.size(); cs_s = cs_runs0.size();
        enable0 = 1'b1;
        push0(8'h3C);
        push0(8'hC3);
        wait_idle0(ok);
        tick();
        total++; if (!ok) begin bad++; $display("FAIL b2b_timeout busy=%b exp=0", busy0); end
        total++; if (rd_cnt0 - rd_s !== 2) begin bad++; $display("FAIL b2b_pops got=%0d exp=2", rd_cnt0 - rd_s); end
        total++; if (rd_gap0 !== 35) begin bad++; $display("FAIL b2b_pop_gap got=%0d exp=35", rd_gap0); end
        total++;
        if (cs_runs0.size() != cs_s + 1) begin bad++; $display("FAIL b2b_cs_runs got=%0d exp=%0d", cs_runs0.size(), cs_s + 1); end
        else if (cs_runs0[cs_s] != 69) begin bad++; $display("FAIL b2b_cs_low got=%0d exp=69", cs_runs0[cs_s]); end
        total++;
        if (rx_q0.size() != rx_s + 2) begin bad++; $display("FAIL b2b_rx_count got=%0d exp=%0d", rx_q0.size(), rx_s + 2); end
        else if (rx_q0[rx_s] !== 8'h3C || rx_q0[rx_s+1] !== 8'hC3)
            begin bad++; $display("FAIL b2b_rx_data got=%h,%h exp=3c,c3", rx_q0[rx_s], rx_q0[rx_s+1]); end
        total++; if (tx_count0 !== 8'd2) begin bad++; $display("FAIL b2b_tx_count got=%0d exp=2", tx_count0); end
    endtask

    task automatic test_empty_idle();
        int viol;
        viol = 0;
        enable0 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (fifo_rd0 || sclk0 || byte_done0 || !cs_n0 || busy0) viol++;
        end
        total++; if (viol != 0) begin bad++; $display("FAIL empty_idle violations got=%0d exp=0", viol); end
        total++; if (tx_count0 !== 8'd2) begin bad++; $display("FAIL empty_tx_count got=%0d exp=2", tx_count0); end
    endtask

    task automatic test_reset_abort();
        int rd_s, done_s, r_s, n;
        rd_s = rd_cnt0; done_s = done_cnt0; r_s = rise_cnt0;
        enable0 = 1'b1;
        push0(8'hFF);
        n = 0;
        while ((rise_cnt0 - r_s) < 5 && n < 200) begin tick(); n++; end
        total++; if ((rise_cnt0 - r_s) != 5) begin bad++; $display("FAIL abort_rises got=%0d exp=5", rise_cnt0 - r_s); end
        rst = 1'b0;
        tick();
        total++; if (cs_n0 !== 1'b1 || sclk0 !== 1'b0 || busy0 !== 1'b0)
            begin bad++; $display("FAIL abort_state cs_n=%b sclk=%b busy=%b exp=1/0/0", cs_n0, sclk0, busy0); end
        total++; if (tx_count0 !== 8'd0) begin bad++; $display("FAIL abort_tx_count got=%0d exp=0", tx_count0); end
        rst = 1'b1;
        repeat (30) tick();
        total++; if (done_cnt0 - done_s !== 0) begin bad++; $display("FAIL abort_byte_done got=%0d exp=0", done_cnt0 - done_s); end
        total++; if (rd_cnt0 - rd_s !== 1) begin bad++; $display("FAIL abort_pops got=%0d exp=1", rd_cnt0 - rd_s); end
    endtask

    task automatic test_enable_drop();
        int rd_s, done_s, r_s, rx_s, n;
        bit ok;
        rd_s = rd_cnt0; done_s = done_cnt0; r_s = rise_cnt0; rx_s = rx_q0.size();
        enable0 = 1'b1;
        push0(8'h81);
        push0(8'h42);
        n = 0;
        while ((rise_cnt0 - r_s) < 3 && n < 200) begin tick(); n++; end
        enable0 = 1'b0;
        n = 0;
        while (busy0 && n < 2000) begin tick(); n++; end
        ok = !busy0;
        tick();
        total++; if (!ok) begin bad++; $display("FAIL drop_timeout busy=%b exp=0", busy0); end
        total++; if (rd_cnt0 - rd_s !== 1) begin bad++; $display("FAIL drop_pops got=%0d exp=1", rd_cnt0 - rd_s); end
        total++; if (done_cnt0 - done_s !== 1) begin bad++; $display("FAIL drop_byte_done got=%0d exp=1", done_cnt0 - done_s); end
        total++;
        if (rx_q0.size() != rx_s + 1) begin bad++; $display("FAIL drop_rx_count got=%0d exp=%0d", rx_q0.size(), rx_s + 1); end
        else if (rx_q0[rx_s] !== 8'h81) begin bad++; $display("FAIL drop_rx_data got=%h exp=81", rx_q0[rx_s]); end
        total++; if (cs_n0 !== 1'b1) begin bad++; $display("FAIL drop_cs_n got=%b exp=1", cs_n0); end
        total++; if (fifo_empty0 !== 1'b0) begin bad++; $display("FAIL drop_fifo_left got_empty=%b exp=0", fifo_empty0); end
        total++; if (tx_count0 !== 8'd1) begin bad++; $display("FAIL drop_tx_count got=%0d exp=1", tx_count0); end
    endtask

    task automatic test_stream_div1();
        int n, mism;
        logic [7:0] b;
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            push1(b);
        end
        enable1 = 1'b1;
        n = 0;
        while (done_cnt1 < 256 && n < 7000) begin tick(); n++; end
        repeat (5) tick();
        total++; if (done_cnt1 != 256) begin bad++; $display("FAIL div1_byte_done got=%0d exp=256", done_cnt1); end
        total++; if (rd_cnt1 != 256) begin bad++; $display("FAIL div1_pops got=%0d exp=256", rd_cnt1); end
        total++; if (gap_bad1 != 0) begin bad++; $display("FAIL div1_pop_gap bad_gaps=%0d exp=0", gap_bad1); end
        total++; if (tx_count1 !== 8'd0) begin bad++; $display("FAIL div1_tx_wrap got=%0d exp=0", tx_count1); end
        mism = 0;
        for (int i = 0; i < rx_q1.size(); i++) begin
            b = 8'(i);
            if (rx_q1[i] !== b) mism++;
        end
        total++; if (rx_q1.size() != 256 || mism != 0)
            begin bad++; $display("FAIL div1_rx_data count=%0d mismatches=%0d exp=256/0", rx_q1.size(), mism); end
        total++; if (cs_n1 !== 1'b1 || busy1 !== 1'b0) begin bad++; $display("FAIL div1_idle cs_n=%b busy=%b exp=1/0", cs_n1, busy1); end
    endtask

    task automatic test_invariants();
        total++; if (sclk_bad != 0) begin bad++; $display("FAIL sclk_with_cs_high got=%0d exp=0", sclk_bad); end
        total++; if (pop_err != 0) begin bad++; $display("FAIL pop_when_empty got=%0d exp=0", pop_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_empty_idle();
        test_reset_abort();
        test_enable_drop();
        test_stream_div1();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
